// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, raster counters, registered sync/active
// decode and a frame counter. All outputs are registered from next-state values.
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        active,
    output logic        hsync,
    output logic        vsync,
    output logic        pixel_tick,
    output logic        frame_tick,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_d, y_d;
    logic [15:0]      fc_d;
    logic             adv;
    logic             tick_d, ftick_d, hsync_d, vsync_d, active_d;

    always_comb begin
        div_d = div_q + 1'b1;
        x_d   = pixel_x;
        y_d   = pixel_y;
        fc_d  = frame_count;
        adv   = (div_q == DIV_LAST);
        if (adv) begin
            div_d = '0;
            if (pixel_x == H_LAST) begin
                x_d = '0;
                if (pixel_y == V_LAST) begin
                    y_d  = '0;
                    fc_d = frame_count + 16'd1;
                end else begin
                    y_d = pixel_y + 10'd1;
                end
            end else begin
                x_d = pixel_x + 10'd1;
            end
        end
    end

    // Decode from next-state counters so outputs line up with pixel_x/pixel_y.
    always_comb begin
        tick_d   = (div_d == DIV_LAST);
        ftick_d  = adv && (x_d == 10'd0) && (y_d == V_DISP);
        hsync_d  = !((x_d >= HS_START) && (x_d <= HS_END));
        vsync_d  = !((y_d >= VS_START) && (y_d <= VS_END));
        active_d = (x_d < H_DISP) && (y_d < V_DISP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= '0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            frame_count <= '0;
            pixel_tick  <= 1'b0;
            frame_tick  <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            active      <= 1'b1;
        end else begin
            div_q       <= div_d;
            pixel_x     <= x_d;
            pixel_y     <= y_d;
            frame_count <= fc_d;
            pixel_tick  <= tick_d;
            frame_tick  <= ftick_d;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            active      <= active_d;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing for reset/first line, plus a tiny CLK_DIV=2
// raster (15x8) for full-frame, frame_tick, frame_count and async reset behaviour.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_def_n, rst_sml_n;
    logic [9:0]  d_x, d_y, s_x, s_y;
    logic        d_act, d_hs, d_vs, d_tick, d_ft;
    logic        s_act, s_hs, s_vs, s_tick, s_ft;
    logic [15:0] d_fc, s_fc;

    vga_sync_gen u_def (
        .clk(clk), .reset_n(rst_def_n), .pixel_x(d_x), .pixel_y(d_y), .active(d_act),
        .hsync(d_hs), .vsync(d_vs), .pixel_tick(d_tick), .frame_tick(d_ft), .frame_count(d_fc)
    );

    // H: 8+2+3+2 = 15 (hsync low x=10..12); V: 4+1+2+1 = 8 (vsync low y=5..6)
    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_sml (
        .clk(clk), .reset_n(rst_sml_n), .pixel_x(s_x), .pixel_y(s_y), .active(s_act),
        .hsync(s_hs), .vsync(s_vs), .pixel_tick(s_tick), .frame_tick(s_ft), .frame_count(s_fc)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_sml_reset(input string pfx);
        check({pfx, "_x"}, 32'(s_x), 0);
        check({pfx, "_y"}, 32'(s_y), 0);
        check({pfx, "_fc"}, 32'(s_fc), 0);
        check({pfx, "_tick"}, 32'(s_tick), 0);
        check({pfx, "_ftick"}, 32'(s_ft), 0);
        check({pfx, "_hsync"}, 32'(s_hs), 1);
        check({pfx, "_vsync"}, 32'(s_vs), 1);
        check({pfx, "_active"}, 32'(s_act), 1);
    endtask

    initial begin
        int edges, hs_low, hs_first, act_fall, vs_low, ft_cnt, ft_x, ft_y, line1, px, py;
        logic prev_act;
        logic found;

        rst_def_n = 1'b0;
        rst_sml_n = 1'b0;
        #23;
        check("def_rst_x", 32'(d_x), 0);
        check("def_rst_y", 32'(d_y), 0);
        check("def_rst_fc", 32'(d_fc), 0);
        check("def_rst_tick", 32'(d_tick), 0);
        check("def_rst_ftick", 32'(d_ft), 0);
        check("def_rst_hsync", 32'(d_hs), 1);
        check("def_rst_vsync", 32'(d_vs), 1);
        check("def_rst_active", 32'(d_act), 1);

        // Default timing: first pixel tick lands in the 4th cycle after release
        @(negedge clk);
        rst_def_n = 1'b1;
        #1;
        check("def_c1_tick", 32'(d_tick), 0);
        step(); check("def_c2_tick", 32'(d_tick), 0);
        step(); check("def_c3_tick", 32'(d_tick), 0);
        step(); check("def_c4_tick", 32'(d_tick), 1);
        check("def_c4_x", 32'(d_x), 0);
        step(); check("def_c5_tick", 32'(d_tick), 0);
        check("def_c5_x", 32'(d_x), 1);
        check("def_c5_active", 32'(d_act), 1);
        check("def_c5_hsync", 32'(d_hs), 1);

        edges = 4; hs_low = 0; hs_first = -1; act_fall = -1; prev_act = d_act;
        while (d_y != 10'd1 && edges < 4000) begin
            step();
            edges++;
            if (!d_hs) begin
                if (hs_low == 0) hs_first = int'(d_x);
                hs_low++;
            end
            if (prev_act && !d_act && act_fall < 0) act_fall = int'(d_x);
            prev_act = d_act;
        end
        check("def_line_clks", 32'(edges), 3200);
        check("def_hsync_low_clks", 32'(hs_low), 384);
        check("def_hsync_first_x", 32'(hs_first), 656);
        check("def_active_fall_x", 32'(act_fall), 640);
        check("def_line1_x", 32'(d_x), 0);
        check("def_line1_y", 32'(d_y), 1);
        check("def_line1_active", 32'(d_act), 1);

        // Small raster with CLK_DIV=2
        check_sml_reset("sml_rst");
        @(negedge clk);
        rst_sml_n = 1'b1;
        step(); check("sml_c2_tick", 32'(s_tick), 1);
        check("sml_c2_x", 32'(s_x), 0);
        step(); check("sml_c3_tick", 32'(s_tick), 0);
        check("sml_c3_x", 32'(s_x), 1);
        step(); check("sml_c4_tick", 32'(s_tick), 1);

        edges = 3; vs_low = 0; ft_cnt = 0; ft_x = -1; ft_y = -1; line1 = -1;
        px = int'(s_x); py = int'(s_y);
        while (s_fc != 16'd1 && edges < 1000) begin
            px = int'(s_x); py = int'(s_y);
            step();
            edges++;
            if (!s_vs) vs_low++;
            if (s_ft) begin
                ft_cnt++;
                ft_x = int'(s_x);
                ft_y = int'(s_y);
            end
            if (line1 < 0 && s_y == 10'd1) line1 = edges;
        end
        check("sml_line_clks", 32'(line1), 30);
        check("sml_frame_clks", 32'(edges), 240);
        check("sml_vsync_low_clks", 32'(vs_low), 60);
        check("sml_ftick_count", 32'(ft_cnt), 1);
        check("sml_ftick_x", 32'(ft_x), 0);
        check("sml_ftick_y", 32'(ft_y), 4);
        check("sml_prewrap_x", 32'(px), 14);
        check("sml_prewrap_y", 32'(py), 7);
        check("sml_wrap_x", 32'(s_x), 0);
        check("sml_wrap_y", 32'(s_y), 0);
        check("sml_wrap_active", 32'(s_act), 1);
        check("sml_wrap_hsync", 32'(s_hs), 1);
        check("sml_wrap_vsync", 32'(s_vs), 1);

        // Mid-frame asynchronous reset at (12,3): hsync is low there
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (s_x == 10'd12 && s_y == 10'd3) found = 1'b1;
        end
        check("sml_reach_12_3", 32'(found), 1);
        check("sml_mid_fc", 32'(s_fc), 1);
        check("sml_mid_hsync", 32'(s_hs), 0);
        #2;
        rst_sml_n = 1'b0;
        #1;
        check_sml_reset("sml_async");
        @(negedge clk);
        rst_sml_n = 1'b1;
        step();
        step();
        check("sml_restart_x", 32'(s_x), 1);
        check("sml_restart_y", 32'(s_y), 0);
        check("sml_restart_fc", 32'(s_fc), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel (100 MHz clk -> 25 MHz pixel rate).
REQ-002 Parameter H_DISPLAY, default 640: visible pixels per line.
REQ-003 Parameter H_FRONT, default 16: horizontal front porch, in pixels.
REQ-004 Parameter H_SYNC, default 96: horizontal sync width, in pixels.
REQ-005 Parameter H_BACK, default 48: horizontal back porch, in pixels.
REQ-006 Parameter V_DISPLAY, default 480: visible lines per frame.
REQ-007 Parameter V_FRONT, default 10: vertical front porch, in lines.
REQ-008 Parameter V_SYNC, default 2: vertical sync width, in lines.
REQ-009 Parameter V_BACK, default 33: vertical back porch, in lines.
REQ-010 clk  input  1: single system clock; all state SHALL update on its rising edge.
REQ-011 reset_n  input  1: asynchronous, active-low reset.
REQ-012 pixel_x  output  10: current horizontal count, range 0..H_TOTAL-1.
REQ-013 pixel_y  output  10: current vertical count, range 0..V_TOTAL-1.
REQ-014 active  output  1: high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY.
REQ-015 hsync  output  1: horizontal sync, active-low.
REQ-016 vsync  output  1: vertical sync, active-low.
REQ-017 pixel_tick  output  1: one-clk pulse marking each pixel advance.
REQ-018 frame_tick  output  1: one-clk pulse at the start of vertical blanking.
REQ-019 frame_count  output  16: number of completed frames, wraps modulo 2^16.

Function
REQ-020 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL equal the V sum (525).
REQ-021 Divider: a counter SHALL count 0..CLK_DIV-1 and wrap to 0.
REQ-022 pixel_tick SHALL be high for exactly the one clk cycle in which the divider equals CLK_DIV-1 (period CLK_DIV clks).
REQ-023 pixel_x SHALL advance only on clock edges where pixel_tick is high; all counters SHALL hold otherwise.
REQ-024 On such an edge, pixel_x SHALL increment, wrapping from H_TOTAL-1 to 0.
REQ-025 pixel_y SHALL increment only on the edge where pixel_x wraps, wrapping from V_TOTAL-1 to 0 (simultaneous wrap: both go to 0).
REQ-026 hsync SHALL be 0 exactly when pixel_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] ([656,751]); else 1.
REQ-027 vsync SHALL be 0 exactly when pixel_y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] ([490,491]); else 1.
REQ-028 hsync, vsync and active SHALL be registered, computed from next-state counter values, so they change on the same edge as pixel_x/pixel_y with zero relative skew and no combinational glitches.
REQ-029 frame_tick SHALL be high for the one clk cycle immediately after the edge on which (pixel_x, pixel_y) becomes (0, V_DISPLAY).
REQ-030 frame_count SHALL increment by 1 on the edge where (pixel_x, pixel_y) wraps to (0,0), wrapping from 65535 to 0.
REQ-031 Counter widths SHALL be 10 bits; parameter sets with H_TOTAL or V_TOTAL > 1024 are unsupported.

Reset
REQ-032 While reset_n=0: divider=0, pixel_x=0, pixel_y=0, frame_count=0, pixel_tick=0, frame_tick=0, hsync=1, vsync=1, active=1 (decode of position 0,0).
REQ-033 Reset assertion mid-frame SHALL take effect immediately without waiting for clk.
REQ-034 After reset_n rises, the first pixel_tick SHALL occur in the CLK_DIV-th clk cycle, and pixel_x SHALL become 1 on that edge.

Verification
REQ-035 Release reset, run 4 clks -> pixel_tick high only in cycle 4; pixel_x 0->1 on that edge; active=1, hsync=1.
REQ-036 Run one line (3200 clks) -> hsync low for exactly 384 clks starting at pixel_x=656; active falls at pixel_x=640; pixel_y=1 after pixel_x wraps at 799.
REQ-037 Run one frame (1,680,000 clks) -> vsync low exactly for lines 490-491 (6400 clks); frame_tick pulses once at (0,480); frame_count 0->1 at wrap to (0,0).
REQ-038 At (799,524) the next pixel_tick -> pixel_x=0, pixel_y=0 on the same edge; active=1, hsync=1, vsync=1.
REQ-039 Assert reset_n low at (700,300) asynchronously -> outputs reach REQ-032 values without a clk edge; counting restarts from (0,0).
REQ-040 Force frame_count to 65535, complete a frame -> frame_count=0; CLK_DIV=2 build -> pixel_tick period 2 clks, line = 1600 clks.
